// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants, FSM encodings and helpers for the UART path
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with occupancy count; shared by TX and RX
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == c_CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Pointer width equals log2(DEPTH), so wrap-around is the natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + c_AW'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + c_AW'(1);
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + c_CW'(1);
            else if (!w_push_ok && w_pop_ok) r_count <= r_count - c_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : FIFO-buffered UART transmitter with elaboration-time framing
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int c_BW  = (c_CPB > 2) ? $clog2(c_CPB) : 1;
    localparam int c_CW  = $clog2(FIFO_DEPTH) + 1;

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || c_CPB < 2) begin : g_bad_params
        $error("uart_tx_fifo: illegal frame or baud parameters");
    end

    tx_state_t            r_state, w_state_next;
    logic [c_BW-1:0]      r_baud, w_baud_next;
    logic [3:0]           r_bit, w_bit_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic                 r_par, w_par_next;
    logic                 r_txd, w_txd_next;
    logic                 r_busy, w_busy_next;
    logic                 w_baud_tick;
    logic                 w_push, w_pop;
    logic                 w_full, w_empty;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;
    logic [c_CW-1:0]      w_count_next;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .i_push  (w_push),
        .i_data  (tx_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign tx_ready    = ~w_full;
    assign w_push      = tx_valid & ~w_full;
    assign w_baud_tick = (r_baud == c_BW'(c_CPB - 1));
    assign w_head_par  = (PARITY == PAR_ODD) ? ~(^w_head) : (^w_head);
    assign uart_txd    = r_txd;
    assign tx_busy     = r_busy;

    // Next occupancy lets tx_busy be registered in step with the state change.
    always_comb begin
        w_count_next = fifo_count;
        if (w_push && !w_pop)      w_count_next = fifo_count + c_CW'(1);
        else if (!w_push && w_pop) w_count_next = fifo_count - c_CW'(1);
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = w_baud_tick ? '0 : r_baud + c_BW'(1);
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_par_next   = r_par;
        w_txd_next   = r_txd;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_baud_next = '0;
                w_txd_next  = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_par_next   = w_head_par;
                    w_state_next = ST_START;
                    w_txd_next   = 1'b0;
                end
            end
            ST_START: begin
                if (w_baud_tick) begin
                    w_state_next = ST_DATA;
                    w_bit_next   = '0;
                    w_txd_next   = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_baud_tick) begin
                    if (r_bit == 4'(DATA_BITS - 1)) begin
                        if (PARITY != PAR_NONE) begin
                            w_state_next = ST_PAR;
                            w_txd_next   = r_par;
                        end else begin
                            w_state_next = ST_STOP;
                            w_bit_next   = '0;
                            w_txd_next   = 1'b1;
                        end
                    end else begin
                        w_shift_next = r_shift >> 1;
                        w_bit_next   = r_bit + 4'd1;
                        w_txd_next   = r_shift[1];
                    end
                end
            end
            ST_PAR: begin
                if (w_baud_tick) begin
                    w_state_next = ST_STOP;
                    w_bit_next   = '0;
                    w_txd_next   = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_baud_tick) begin
                    if (r_bit == 4'(STOP_BITS - 1)) begin
                        if (!w_empty) begin
                            w_pop        = 1'b1;
                            w_shift_next = w_head;
                            w_par_next   = w_head_par;
                            w_state_next = ST_START;
                            w_txd_next   = 1'b0;
                        end else begin
                            w_state_next = ST_IDLE;
                            w_txd_next   = 1'b1;
                        end
                    end else begin
                        w_bit_next = r_bit + 4'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_txd_next   = 1'b1;
            end
        endcase
    end

    assign w_busy_next = (w_state_next != ST_IDLE) || (w_count_next != '0);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_par   <= w_par_next;
            r_txd   <= w_txd_next;
            r_busy  <= w_busy_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Scoreboard bench; four DUTs (8N1/8E1/8O1/7N2, depth 4)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] dat [3];
    logic [6:0] dat7;
    logic       vld  [4];
    logic       rdy  [4];
    logic       txd  [4];
    logic       busy [4];
    logic [2:0] cnt  [4];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_start [4];

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       pbit;
        bit         gap;
    } exp_t;
    exp_t exp_q[$];

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_dut_a (.sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(dat[0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
             .uart_txd(txd[0]), .tx_busy(busy[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_dut_b (.sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(dat[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
             .uart_txd(txd[1]), .tx_busy(busy[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_dut_c (.sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(dat[2]), .tx_valid(vld[2]), .tx_ready(rdy[2]),
             .uart_txd(txd[2]), .tx_busy(busy[2]), .fifo_count(cnt[2]));
    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    u_dut_d (.sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(dat7), .tx_valid(vld[3]), .tx_ready(rdy[3]),
             .uart_txd(txd[3]), .tx_busy(busy[3]), .fifo_count(cnt[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_n(input int n, inout bit ab);
        repeat (n) begin
            if (ab) return;
            @(negedge sys_clk);
            if (sys_rst) ab = 1'b1;
        end
    endtask

    // Serial receiver model: samples mid-bit and scores each complete frame.
    task automatic monitor(input int id);
        int         nbits   = (id == 3) ? 7 : 8;
        int         nstop   = (id == 3) ? 2 : 1;
        bit         has_par = (id == 1 || id == 2);
        int         flen    = (1 + nbits + (has_par ? 1 : 0) + nstop) * 4;
        logic [7:0] d;
        logic       p;
        logic       st_ok;
        logic       start_ok;
        int         t0;
        bit         ab;
        exp_t       e;
        forever begin
            @(negedge sys_clk);
            if (sys_rst || txd[id] !== 1'b0) continue;
            t0 = cyc; ab = 1'b0; d = '0; p = 1'b0; st_ok = 1'b1;
            wait_n(2, ab);
            start_ok = (txd[id] === 1'b0);
            for (int k = 0; k < nbits; k++) begin
                wait_n(4, ab);
                d[k] = txd[id];
            end
            if (has_par) begin
                wait_n(4, ab);
                p = txd[id];
            end
            for (int k = 0; k < nstop; k++) begin
                wait_n(4, ab);
                if (txd[id] !== 1'b1) st_ok = 1'b0;
            end
            if (ab) continue;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_frame dut%0d: got data %h expected no frame", id, d);
                continue;
            end
            e = exp_q.pop_front();
            check($sformatf("frame_dut%0d", id), id, e.id);
            check($sformatf("data_dut%0d", id), d, e.data);
            check($sformatf("start_dut%0d", id), start_ok, 1);
            check($sformatf("stop_dut%0d", id), st_ok, 1);
            if (has_par) check($sformatf("parity_dut%0d", id), p, e.pbit);
            if (e.gap) check($sformatf("b2b_gap_dut%0d", id), t0 - last_start[id], flen);
            last_start[id] = t0;
        end
    endtask

    task automatic push(input int id, input logic [7:0] val, input bit rdy_exp, input bit frame,
                        input bit gap, input logic pbit, input int exp_cnt);
        exp_t e;
        if (id == 3) dat7 = val[6:0];
        else         dat[id] = val;
        vld[id] = 1'b1;
        check($sformatf("tx_ready_dut%0d", id), rdy[id], rdy_exp);
        if (frame) begin
            e.id = id; e.data = val; e.pbit = pbit; e.gap = gap;
            exp_q.push_back(e);
        end
        @(negedge sys_clk);
        vld[id] = 1'b0;
        check($sformatf("fifo_count_dut%0d", id), cnt[id], exp_cnt);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        repeat (6) @(negedge sys_clk);
    endtask

    task automatic busy_len(input int id, input int exp_len);
        int n = 0;
        while (busy[id] === 1'b1 && n < 200) begin
            n++;
            @(negedge sys_clk);
        end
        check($sformatf("busy_len_dut%0d", id), n, exp_len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        foreach (vld[i]) vld[i] = 1'b0;
        foreach (dat[i]) dat[i] = '0;
        foreach (last_start[i]) last_start[i] = 0;
        dat7 = '0;
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
        join_none

        repeat (3) @(negedge sys_clk);
        check("rst_txd", txd[0], 1);
        check("rst_busy", busy[0], 0);
        check("rst_ready", rdy[0], 1);
        check("rst_count", cnt[0], 0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // 8N1 single byte, frame plus busy duration
        push(0, 8'hA5, 1, 1, 0, 0, 1);
        busy_len(0, 41);
        wait_drain(100);

        // parity variants
        push(1, 8'hA5, 1, 1, 0, 0, 1);
        wait_drain(100);
        push(2, 8'hA5, 1, 1, 0, 1, 1);
        wait_drain(100);
        push(2, 8'h01, 1, 1, 0, 0, 1);
        wait_drain(100);

        // three back-to-back bytes
        push(0, 8'h11, 1, 1, 0, 0, 1);
        push(0, 8'h22, 1, 1, 1, 0, 1);
        push(0, 8'h33, 1, 1, 1, 0, 2);
        repeat (39) @(negedge sys_clk);
        check("count_after_frame2_start", cnt[0], 1);
        repeat (40) @(negedge sys_clk);
        check("count_after_frame3_start", cnt[0], 0);
        wait_drain(200);

        // overflow: sixth word dropped
        push(0, 8'hC3, 1, 1, 0, 0, 1);
        push(0, 8'h5A, 1, 1, 1, 0, 1);
        push(0, 8'h0F, 1, 1, 1, 0, 2);
        push(0, 8'hF0, 1, 1, 1, 0, 3);
        push(0, 8'h99, 1, 1, 1, 0, 4);
        push(0, 8'h66, 0, 0, 0, 0, 4);
        wait_drain(400);

        // reset during data bit 3 of the second frame
        push(0, 8'h55, 1, 1, 0, 0, 1);
        push(0, 8'h66, 1, 0, 0, 0, 1);
        push(0, 8'h77, 1, 0, 0, 0, 2);
        repeat (55) @(negedge sys_clk);
        check("mid_frame_line", txd[0], 0);
        #1 sys_rst = 1'b1;
        #1;
        check("async_rst_txd", txd[0], 1);
        check("async_rst_count", cnt[0], 0);
        check("async_rst_busy", busy[0], 0);
        check("async_rst_ready", rdy[0], 1);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        push(0, 8'h3C, 1, 1, 0, 0, 1);
        wait_drain(100);

        // 7 data bits, 2 stop bits
        push(3, 8'h7F, 1, 1, 0, 0, 1);
        busy_len(3, 41);
        wait_drain(100);

        repeat (20) @(negedge sys_clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
